// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial add/subtract engine.
package nsa_pkg;

  // Width of the shared adder slice
  localparam int unsigned NIBBLE_W = 4;

  // Control FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : nsa_pkg

// File: rtl/FA_4bit_df.sv
// 4-bit dataflow adder slice: {Cout, s} = a + b + Cin.
module FA_4bit_df (
  output logic [3:0] s,
  output logic       Cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       Cin
);

  // Single ripple sum with the carry taken from the fifth bit
  assign {Cout, s} = 5'(a) + 5'(b) + 5'(Cin);

endmodule : FA_4bit_df

// File: rtl/nibble_serial_adder.sv
// Multi-word add/subtract engine streaming operands through one 4-bit slice,
// least-significant nibble first, with a registered inter-nibble carry.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned NIB  = WIDTH / NIBBLE_W;
  localparam int unsigned CNTW = (NIB > 1) ? $clog2(NIB) : 1;
  // Partial result: the nibbles completed before the last one
  localparam int unsigned RW   = WIDTH - NIBBLE_W;

  state_t              state;
  state_t              state_nxt;
  logic [WIDTH-1:0]    a_sh;
  logic [WIDTH-1:0]    b_sh;
  logic [RW-1:0]       sum_sh;
  logic                carry;
  logic [CNTW-1:0]     cnt;
  logic                last_c;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;

  // Slice hookup: always the low nibble of the operand shifters
  assign slice_a = a_sh[NIBBLE_W-1:0];
  assign slice_b = b_sh[NIBBLE_W-1:0];
  assign last_c  = (cnt == CNTW'(NIB - 1));

  FA_4bit_df u_slice (
    .s    (slice_s),
    .Cout (slice_cout),
    .a    (slice_a),
    .b    (slice_b),
    .Cin  (carry)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
      ST_RUN:  if (last_c)    state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered handshake flags decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ST_IDLE);
      out_valid <= (state_nxt == ST_DONE);
    end
  end

  // Operand shifters, carry, nibble counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_sh  <= in_a;
            b_sh  <= in_sub ? ~in_b : in_b;
            carry <= in_sub ? 1'b1 : in_cin;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          sum_sh <= RW'({slice_s, sum_sh} >> NIBBLE_W);
          a_sh   <= a_sh >> NIBBLE_W;
          b_sh   <= b_sh >> NIBBLE_W;
          carry  <= slice_cout;
          cnt    <= cnt + CNTW'(1);
          // Last nibble completes the word and fixes the flags
          if (last_c) begin
            out_sum  <= {slice_s, sum_sh};
            out_cout <= slice_cout;
            out_ovf  <= (slice_a[NIBBLE_W-1] == slice_b[NIBBLE_W-1]) &&
                        (slice_s[NIBBLE_W-1] != slice_a[NIBBLE_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request while idle; operands are scrambled right after the accept edge
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    @(negedge clk);
    in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'hBEEF; in_cin = 1'b1; in_sub = ~sub;
  endtask

  // Count falling edges until out_valid, bounded by a cycle budget
  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Accept the result for one edge
  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
    #12;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if ({out_sum, out_cout, out_ovf} !== 18'h0) begin n_bad++; $display("FAIL reset_outputs got %h/%b/%b want 0/0/0", out_sum, out_cout, out_ovf); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_ripple();
    int n;
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_done(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL add_latency got %0d want 4", n); end
    n_cmp++; if (out_sum !== 16'h0100) begin n_bad++; $display("FAIL add_sum got %h want 0100", out_sum); end
    n_cmp++; if ({out_cout, out_ovf} !== 2'b00) begin n_bad++; $display("FAIL add_flags got %b%b want 00", out_cout, out_ovf); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL add_busy got %b want 0", in_ready); end
    release_result();
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL add_release got %b%b want 01", out_valid, in_ready); end
  endtask

  task automatic test_wrap();
    int n;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(n);
    n_cmp++; if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL wrap_ffff got v=%b %h c=%b o=%b want v=1 0000 c=1 o=0", out_valid, out_sum, out_cout, out_ovf); end
    release_result();
    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(n);
    n_cmp++; if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, 16'h8000, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL wrap_7fff got v=%b %h c=%b o=%b want v=1 8000 c=0 o=1", out_valid, out_sum, out_cout, out_ovf); end
    release_result();
    start_op(16'h1234, 16'h0FFF, 1'b1, 1'b0);
    wait_done(n);
    n_cmp++; if ({out_sum, out_cout, out_ovf} !== {16'h2234, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL add_cin got %h c=%b o=%b want 2234 c=0 o=0", out_sum, out_cout, out_ovf); end
    release_result();
  endtask

  task automatic test_subtract();
    int n;
    start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_done(n);
    n_cmp++; if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, 16'hFFFE, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL sub_5_7 got v=%b %h c=%b o=%b want v=1 fffe c=0 o=0", out_valid, out_sum, out_cout, out_ovf); end
    release_result();
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done(n);
    n_cmp++; if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, 16'h7FFF, 1'b1, 1'b1}) begin
      n_bad++; $display("FAIL sub_8000_1 got v=%b %h c=%b o=%b want v=1 7fff c=1 o=1", out_valid, out_sum, out_cout, out_ovf); end
    release_result();
  endtask

  task automatic test_backpressure();
    int n;
    start_op(16'h1234, 16'h0001, 1'b0, 1'b0);
    wait_done(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if ({out_valid, in_ready, out_sum} !== {1'b1, 1'b0, 16'h1235}) begin
        n_bad++; $display("FAIL hold_%0d got v=%b r=%b %h want v=1 r=0 1235", i, out_valid, in_ready, out_sum); end
    end
    release_result();
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_release got %b%b want 01", out_valid, in_ready); end
    n_cmp++; if (out_sum !== 16'h1235) begin n_bad++; $display("FAIL bp_sum_held got %h want 1235", out_sum); end
  endtask

  task automatic test_busy_request();
    int n;
    start_op(16'h0100, 16'h0022, 1'b0, 1'b0);
    // Second request raised mid-RUN and held
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h0022; in_cin = 1'b0; in_sub = 1'b0;
    wait_done(n);
    n_cmp++; if ({out_valid, out_sum} !== {1'b1, 16'h0122}) begin
      n_bad++; $display("FAIL busy_first got v=%b %h want v=1 0122", out_valid, out_sum); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready got %b want 0", in_ready); end
    release_result();
    // Back in IDLE with the request still pending; accepted on the next edge
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL busy_idle got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; in_a = 16'h0000;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL busy_accept got %b want 0", in_ready); end
    wait_done(n);
    n_cmp++; if ({out_valid, out_sum} !== {1'b1, 16'h1133}) begin
      n_bad++; $display("FAIL busy_second got v=%b %h want v=1 1133", out_valid, out_sum); end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int n;
    int seen;
    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_bad++; $display("FAIL abort_hs got %b%b want 10", in_ready, out_valid); end
    n_cmp++; if ({out_sum, out_cout, out_ovf} !== 18'h0) begin n_bad++; $display("FAIL abort_out got %h/%b/%b want 0/0/0", out_sum, out_cout, out_ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_result got %0d valid cycles want 0", seen); end
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(n);
    n_cmp++; if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, 16'h5555, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL after_abort got v=%b %h c=%b o=%b want v=1 5555 c=0 o=0", out_valid, out_sum, out_cout, out_ovf); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_add_ripple();
    test_wrap();
    test_subtract();
    test_backpressure();
    test_busy_request();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_nibble_serial_adder
